// File: rtl/wca_sample_framer_if.sv
// Sample/FIFO-side bundle for wca_sample_framer: sample input, FIFO write port,
// status outputs and the FSM state for debug visibility.
interface wca_sample_framer_if;
   logic        enable;
   logic        smp_strobe;
   logic [15:0] smp_i;
   logic [15:0] smp_q;
   logic        fifo_full;
   logic        wr_en;
   logic [31:0] wr_out;
   logic [7:0]  seq_num;
   logic [15:0] overflow_cnt;
   logic        busy;
   logic [2:0]  state_dbg;

   // Handshake: a word moves into the FIFO in every cycle where wr_en is high;
   // the framer raises wr_en only for words produced in a cycle that sampled
   // fifo_full low, so the FIFO never needs to push back on a raised wr_en.
   modport slave (
      input  enable, smp_strobe, smp_i, smp_q, fifo_full,
      output wr_en, wr_out, seq_num, overflow_cnt, busy, state_dbg
   );

   modport master (
      output enable, smp_strobe, smp_i, smp_q, fifo_full,
      input  wr_en, wr_out, seq_num, overflow_cnt, busy, state_dbg
   );
endinterface

// File: rtl/wca_sample_framer.sv
// Packs I/Q samples into fixed-length packets (header + payload) for a FIFO.
// Optional macro WCA_FRAMER_TIMESTAMP_EN adds a timestamp word after the header.
module wca_sample_framer #(
   parameter int         PAYLOAD_WORDS = 128,
   parameter logic [7:0] SYNC_BYTE     = 8'hA5
) (
   input logic              clk,
   input logic              reset,
   wca_sample_framer_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HDR     = 3'd1,
`ifdef WCA_FRAMER_TIMESTAMP_EN
      TS      = 3'd2,
`endif
      PAYLOAD = 3'd3,
      PAD     = 3'd4
   } state_t;

   localparam logic [15:0] PKT_WORDS = 16'(PAYLOAD_WORDS);
   localparam logic [15:0] LAST_WORD = 16'(PAYLOAD_WORDS - 1);

   state_t      state;
   state_t      state_next;
   logic [15:0] word_cnt;
   logic [15:0] word_cnt_next;
   logic [7:0]  seq_q;
   logic [7:0]  seq_next;
   logic [15:0] ovf_q;
   logic        wr_en_q;
   logic [31:0] wr_out_q;

   logic        do_write;
   logic [31:0] write_data;
   logic        seq_load;
   logic        drop;

`ifdef WCA_FRAMER_TIMESTAMP_EN
   logic [31:0] ts_cnt;
   logic [31:0] ts_cap;
   logic        ts_load;
`endif

   assign seq_next = seq_q + 8'd1;

   always_comb begin
      state_next    = state;
      word_cnt_next = word_cnt;
      do_write      = 1'b0;
      write_data    = 32'h0;
      seq_load      = 1'b0;
      drop          = 1'b0;
`ifdef WCA_FRAMER_TIMESTAMP_EN
      ts_load       = 1'b0;
`endif
      case (state)
         IDLE: begin
            drop = bus.smp_strobe & bus.enable;
            if (bus.enable) state_next = HDR;
         end
         HDR: begin
            drop = bus.smp_strobe & bus.enable;
            // Dropping enable before the header goes out leaves seq_num untouched.
            if (!bus.enable) begin
               state_next = IDLE;
            end else if (!bus.fifo_full) begin
               do_write   = 1'b1;
               write_data = {SYNC_BYTE, seq_next, PKT_WORDS};
               seq_load   = 1'b1;
`ifdef WCA_FRAMER_TIMESTAMP_EN
               ts_load    = 1'b1;
               state_next = TS;
`else
               state_next = PAYLOAD;
`endif
            end
         end
`ifdef WCA_FRAMER_TIMESTAMP_EN
         TS: begin
            drop = bus.smp_strobe & bus.enable;
            if (!bus.enable) begin
               state_next = IDLE;
            end else if (!bus.fifo_full) begin
               do_write   = 1'b1;
               write_data = ts_cap;
               state_next = PAYLOAD;
            end
         end
`endif
         PAYLOAD: begin
            // A sample accepted in the same cycle enable falls still counts;
            // if it completes the packet there is nothing left to pad.
            if (bus.smp_strobe && !bus.fifo_full) begin
               do_write   = 1'b1;
               write_data = {bus.smp_q, bus.smp_i};
               if (word_cnt == LAST_WORD) begin
                  word_cnt_next = 16'h0;
                  state_next    = bus.enable ? HDR : IDLE;
               end else begin
                  word_cnt_next = word_cnt + 16'd1;
                  if (!bus.enable) state_next = PAD;
               end
            end else begin
               drop = bus.smp_strobe;
               if (!bus.enable) state_next = PAD;
            end
         end
         PAD: begin
            drop = bus.smp_strobe & bus.enable;
            if (!bus.fifo_full) begin
               do_write = 1'b1;
               if (word_cnt == LAST_WORD) begin
                  word_cnt_next = 16'h0;
                  state_next    = IDLE;
               end else begin
                  word_cnt_next = word_cnt + 16'd1;
               end
            end
         end
         default: begin
            state_next    = IDLE;
            word_cnt_next = 16'h0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         word_cnt <= 16'h0;
         seq_q    <= 8'hFF;
         ovf_q    <= 16'h0;
         wr_en_q  <= 1'b0;
         wr_out_q <= 32'h0;
      end else begin
         state    <= state_next;
         word_cnt <= word_cnt_next;
         wr_en_q  <= do_write;
         if (do_write) wr_out_q <= write_data;
         if (seq_load) seq_q <= seq_next;
         if (drop && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
      end
   end

`ifdef WCA_FRAMER_TIMESTAMP_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         ts_cnt <= 32'h0;
         ts_cap <= 32'h0;
      end else begin
         ts_cnt <= ts_cnt + 32'd1;
         if (ts_load) ts_cap <= ts_cnt;
      end
   end
`endif

   assign bus.wr_en        = wr_en_q;
   assign bus.wr_out       = wr_out_q;
   assign bus.seq_num      = seq_q;
   assign bus.overflow_cnt = ovf_q;
   assign bus.busy         = (state != IDLE);
   assign bus.state_dbg    = state;

endmodule

// File: tb/tb_wca_sample_framer.sv
// Directed-vector bench for wca_sample_framer (PAYLOAD_WORDS=4) with a
// queue-based scoreboard checking every FIFO write.
module tb_wca_sample_framer;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
`ifdef WCA_FRAMER_TIMESTAMP_EN
  localparam int PER = 6;
`else
  localparam int PER = 5;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  wca_sample_framer_if bus ();

  wca_sample_framer #(.PAYLOAD_WORDS(4), .SYNC_BYTE(8'hA5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  kind_q[$];
  logic [31:0] cyc = 32'h0;
  logic [31:0] hdr_cyc = 32'h0;

  always @(posedge clk) begin
    if (reset) cyc <= 32'h0;
    else       cyc <= cyc + 32'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write popped against the expected queue.
  always @(negedge clk) begin
    logic [31:0] e;
    logic [1:0]  k;
    if (bus.wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %h expected no write at %0t", bus.wr_out, $time);
      end else begin
        e = exp_q.pop_front();
        k = kind_q.pop_front();
        if (k == 2'd1) hdr_cyc = cyc - 32'd1;
        if (k == 2'd2) e = hdr_cyc;
        check("wr_out", bus.wr_out, e);
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back(w);
    kind_q.push_back(2'd0);
  endtask

  task automatic push_hdr(input logic [7:0] seq);
    exp_q.push_back({8'hA5, seq, 16'd4});
    kind_q.push_back(2'd1);
`ifdef WCA_FRAMER_TIMESTAMP_EN
    exp_q.push_back(32'h0);
    kind_q.push_back(2'd2);
`endif
  endtask

  task automatic drive(input logic en, input logic stb, input logic [15:0] i,
                       input logic [15:0] q, input logic full);
    bus.enable     = en;
    bus.smp_strobe = stb;
    bus.smp_i      = i;
    bus.smp_q      = q;
    bus.fifo_full  = full;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input logic en, input string name);
    for (int n = 0; n < 50; n++) begin
      if (bus.state_dbg == s) return;
      drive(en, 1'b0, 16'h0, 16'h0, 1'b0);
    end
    check(name, {29'h0, bus.state_dbg}, {29'h0, s});
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 20; n++) begin
      if (exp_q.size() == 0) break;
      drive(bus.enable, 1'b0, 16'h0, 16'h0, 1'b0);
    end
    check(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.smp_strobe = 1'b0;
    bus.smp_i = 16'h0;
    bus.smp_q = 16'h0;
    bus.fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_wr_en", {31'h0, bus.wr_en}, 32'd0);
    check("rst_wr_out", bus.wr_out, 32'h0);
    check("rst_seq", {24'h0, bus.seq_num}, 32'hFF);
    check("rst_ovf", {16'h0, bus.overflow_cnt}, 32'h0);
    check("rst_busy", {31'h0, bus.busy}, 32'd0);

    // Basic packet, seq 00.
    push_hdr(8'h00);
    drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    wait_state(ST_PAYLOAD, 1'b1, "t1_reach_payload");
    check("t1_busy", {31'h0, bus.busy}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      push_word({16'h1000, 16'(k)});
      drive(k != 4, 1'b1, 16'(k), 16'h1000, 1'b0);
    end
    drain("t1_drain");
    check("t1_seq", {24'h0, bus.seq_num}, 32'h00);
    check("t1_ovf", {16'h0, bus.overflow_cnt}, 32'h0);
    check("t1_busy_end", {31'h0, bus.busy}, 32'd0);

    // FIFO full on the 2nd of 5 strobes: that sample is dropped.
    push_hdr(8'h01);
    drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    wait_state(ST_PAYLOAD, 1'b1, "t2_reach_payload");
    for (int k = 1; k <= 5; k++) begin
      if (k != 2) push_word({16'h2000, 16'(k)});
      drive(k != 5, 1'b1, 16'(k), 16'h2000, k == 2);
    end
    drain("t2_drain");
    check("t2_ovf", {16'h0, bus.overflow_cnt}, 32'd1);
    check("t2_state", {29'h0, bus.state_dbg}, {29'h0, ST_IDLE});

    // Enable drops after 2 payload words: two pad words follow.
    push_hdr(8'h02);
    drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    wait_state(ST_PAYLOAD, 1'b1, "t3_reach_payload");
    push_word(32'h3000_0001);
    drive(1'b1, 1'b1, 16'h0001, 16'h3000, 1'b0);
    push_word(32'h3000_0002);
    drive(1'b1, 1'b1, 16'h0002, 16'h3000, 1'b0);
    push_word(32'h0);
    push_word(32'h0);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    wait_state(ST_IDLE, 1'b0, "t3_reach_idle");
    drain("t3_drain");
    check("t3_busy", {31'h0, bus.busy}, 32'd0);
    check("t3_seq", {24'h0, bus.seq_num}, 32'h02);

    // Header stalled by fifo_full; strobes in HDR are dropped and counted.
    drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b1);
    drive(1'b1, 1'b1, 16'h00AA, 16'h0, 1'b1);
    check("t4_stall_wr_en_a", {31'h0, bus.wr_en}, 32'd0);
    drive(1'b1, 1'b1, 16'h00BB, 16'h0, 1'b1);
    check("t4_stall_wr_en_b", {31'h0, bus.wr_en}, 32'd0);
    push_hdr(8'h03);
    wait_state(ST_PAYLOAD, 1'b1, "t4_reach_payload");
    for (int k = 1; k <= 4; k++) begin
      push_word({16'h4000, 16'(k)});
      drive(k != 4, 1'b1, 16'(k), 16'h4000, 1'b0);
    end
    drain("t4_drain");
    check("t4_ovf", {16'h0, bus.overflow_cnt}, 32'd3);
    check("t4_seq", {24'h0, bus.seq_num}, 32'h03);

    // Enable withdrawn in HDR before the header is written: packet abandoned.
    drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b1);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    check("t5_seq", {24'h0, bus.seq_num}, 32'h03);
    check("t5_busy", {31'h0, bus.busy}, 32'd0);

    // Reset after the 3rd payload word: no padding, counters cleared.
    push_hdr(8'h04);
    drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    wait_state(ST_PAYLOAD, 1'b1, "t6_reach_payload");
    for (int k = 1; k <= 3; k++) begin
      push_word({16'h6000, 16'(k)});
      drive(1'b1, 1'b1, 16'(k), 16'h6000, 1'b0);
    end
    reset = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    reset = 1'b0;
    repeat (4) drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    check("t6_no_more_writes", exp_q.size(), 32'd0);
    check("t6_ovf", {16'h0, bus.overflow_cnt}, 32'h0);
    check("t6_seq", {24'h0, bus.seq_num}, 32'hFF);
    check("t6_busy", {31'h0, bus.busy}, 32'd0);

    // 300 back-to-back packets with a strobe every cycle; HDR-cycle strobes drop.
    push_hdr(8'h00);
    drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    wait_state(ST_PAYLOAD, 1'b1, "t7_reach_payload");
    for (int k = 0; k < 299 * PER + 4; k++) begin
      int pkt;
      int pos;
      pkt = k / PER;
      pos = k % PER;
      if (pos < 4) push_word({16'h7000, 16'(k)});
      if (pos == 4) push_hdr(8'(pkt + 1));
      drive(k != 299 * PER + 3, 1'b1, 16'(k), 16'h7000, 1'b0);
    end
    drain("t7_drain");
    check("t7_seq", {24'h0, bus.seq_num}, 32'd43);
    check("t7_ovf", {16'h0, bus.overflow_cnt}, 32'(299 * (PER - 4)));
    check("t7_busy", {31'h0, bus.busy}, 32'd0);

    repeat (3) drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
